// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: single-clock FIFO with standard or first-word-fall-through read, count and status flags
// Define SYNC_FIFO_PARITY_EN to store an even-parity bit per word and add the par_inj/par_err ports.
module sync_fifo_v2 #(
   parameter int DATA_W    = 64,
   parameter int DEPTH     = 256,
   parameter int FWFT      = 0,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   wr_en,
   input  logic [DATA_W-1:0]      wr_data,
   output logic                   full,
   output logic                   almost_full,
   input  logic                   rd_en,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   valid,
   output logic                   empty,
   output logic                   almost_empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   underflow
`ifdef SYNC_FIFO_PARITY_EN
   ,
   input  logic                   par_inj,
   output logic                   par_err
`endif
);
   localparam int AW = $clog2(DEPTH);
`ifdef SYNC_FIFO_PARITY_EN
   localparam int MW = DATA_W + 1;
`else
   localparam int MW = DATA_W;
`endif
   logic [MW-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic [MW-1:0] wr_word, head;
   logic mem_empty, wr_acc, rd_acc, load;
   // In FWFT mode the prefetched output word is still part of the occupancy.
   assign mem_empty = wr_ptr == rd_ptr;
   assign count = (wr_ptr - rd_ptr) + (AW+1)'(FWFT != 0 && valid);
   assign full = count == (AW+1)'(DEPTH);
   assign almost_full = count >= (AW+1)'(AF_THRESH);
   assign almost_empty = count <= (AW+1)'(AE_THRESH);
   assign empty = (FWFT != 0) ? !valid : mem_empty;
   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;
   assign load = (FWFT != 0) ? (!mem_empty && (!valid || rd_en)) : rd_acc;
   assign head = mem[rd_ptr[AW-1:0]];
`ifdef SYNC_FIFO_PARITY_EN
   assign wr_word = {^wr_data ^ par_inj, wr_data};
`else
   assign wr_word = wr_data;
`endif
   always_ff @(posedge clk)
      if (wr_acc && !clr) mem[wr_ptr[AW-1:0]] <= wr_word;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         rd_data   <= '0;
         valid     <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
`ifdef SYNC_FIFO_PARITY_EN
         par_err   <= 1'b0;
`endif
      end else if (clr) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         rd_data   <= '0;
         valid     <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
`ifdef SYNC_FIFO_PARITY_EN
         par_err   <= 1'b0;
`endif
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (load) rd_ptr <= rd_ptr + (AW+1)'(1);
         if (wr_en && full) overflow <= 1'b1;
         if (rd_en && empty) underflow <= 1'b1;
         // Standard mode pulses valid; FWFT holds the head word until it is popped.
         if (load) begin
            rd_data <= head[DATA_W-1:0];
            valid   <= 1'b1;
`ifdef SYNC_FIFO_PARITY_EN
            par_err <= ^head;
`endif
         end else if (FWFT == 0 || rd_en) begin
            valid   <= 1'b0;
`ifdef SYNC_FIFO_PARITY_EN
            par_err <= 1'b0;
`endif
         end
      end
endmodule

// File: tb/tb_sync_fifo_v2.sv
// tb_sync_fifo_v2: directed vector bench for sync_fifo_v2, one standard-mode and one FWFT instance
module tb_sync_fifo_v2;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;
   logic s_clr, s_wr, s_rd, s_full, s_af, s_vld, s_emp, s_ae, s_ov, s_un;
   logic [7:0] s_wd, s_rdd;
   logic [3:0] s_cnt;
   logic f_clr, f_wr, f_rd, f_full, f_af, f_vld, f_emp, f_ae, f_ov, f_un;
   logic [7:0] f_wd, f_rdd;
   logic [3:0] f_cnt;
`ifdef SYNC_FIFO_PARITY_EN
   logic s_pinj, s_perr, f_pinj, f_perr;
`endif
   sync_fifo_v2 #(.DATA_W(8), .DEPTH(8), .FWFT(0), .AF_THRESH(6), .AE_THRESH(2)) u_std (
      .clk(clk), .rst_n(rst_n), .clr(s_clr), .wr_en(s_wr), .wr_data(s_wd), .full(s_full),
      .almost_full(s_af), .rd_en(s_rd), .rd_data(s_rdd), .valid(s_vld), .empty(s_emp),
      .almost_empty(s_ae), .count(s_cnt), .overflow(s_ov), .underflow(s_un)
`ifdef SYNC_FIFO_PARITY_EN
      , .par_inj(s_pinj), .par_err(s_perr)
`endif
   );
   sync_fifo_v2 #(.DATA_W(8), .DEPTH(8), .FWFT(1), .AF_THRESH(6), .AE_THRESH(2)) u_fw (
      .clk(clk), .rst_n(rst_n), .clr(f_clr), .wr_en(f_wr), .wr_data(f_wd), .full(f_full),
      .almost_full(f_af), .rd_en(f_rd), .rd_data(f_rdd), .valid(f_vld), .empty(f_emp),
      .almost_empty(f_ae), .count(f_cnt), .overflow(f_ov), .underflow(f_un)
`ifdef SYNC_FIFO_PARITY_EN
      , .par_inj(f_pinj), .par_err(f_perr)
`endif
   );
   typedef struct {
      logic clr, wr, rd;
      logic [7:0] wd;
      logic [3:0] cnt;
      logic emp, ful, af, ae, vld;
      logic [7:0] rdd;
      logic ov, un;
   } vec_t;
   vec_t vt[$];
   int n_chk = 0;
   int n_fail = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic drv_s(input logic c, input logic w, input logic [7:0] d, input logic r);
      s_clr = c; s_wr = w; s_wd = d; s_rd = r;
   endtask
   task automatic drv_f(input logic w, input logic [7:0] d, input logic r);
      f_wr = w; f_wd = d; f_rd = r;
   endtask
   task automatic chk_s(input string t, input logic [3:0] cnt, input logic emp, input logic ful,
                        input logic af, input logic ae, input logic vld, input logic [7:0] rdd,
                        input logic ov, input logic un);
      chk({t, " count"}, 32'(s_cnt), 32'(cnt));
      chk({t, " empty"}, 32'(s_emp), 32'(emp));
      chk({t, " full"}, 32'(s_full), 32'(ful));
      chk({t, " almost_full"}, 32'(s_af), 32'(af));
      chk({t, " almost_empty"}, 32'(s_ae), 32'(ae));
      chk({t, " valid"}, 32'(s_vld), 32'(vld));
      chk({t, " rd_data"}, 32'(s_rdd), 32'(rdd));
      chk({t, " overflow"}, 32'(s_ov), 32'(ov));
      chk({t, " underflow"}, 32'(s_un), 32'(un));
   endtask
   task automatic chk_f(input string t, input logic [3:0] cnt, input logic emp, input logic vld,
                        input logic [7:0] rdd, input logic use_d);
      chk({t, " count"}, 32'(f_cnt), 32'(cnt));
      chk({t, " empty"}, 32'(f_emp), 32'(emp));
      chk({t, " valid"}, 32'(f_vld), 32'(vld));
      if (use_d) chk({t, " rd_data"}, 32'(f_rdd), 32'(rdd));
   endtask
   initial begin
      // fields: clr wr rd wd | cnt emp full af ae vld rd_data ov un
      vt.push_back('{0,1,0,8'h11, 1,0,0,0,1,0,8'h00,0,0});
      vt.push_back('{0,1,0,8'h22, 2,0,0,0,1,0,8'h00,0,0});
      vt.push_back('{0,1,0,8'h33, 3,0,0,0,0,0,8'h00,0,0});
      vt.push_back('{1,1,0,8'h44, 0,1,0,0,1,0,8'h00,0,0});
      vt.push_back('{0,1,0,8'h01, 1,0,0,0,1,0,8'h00,0,0});
      vt.push_back('{0,1,0,8'h02, 2,0,0,0,1,0,8'h00,0,0});
      vt.push_back('{0,1,0,8'h03, 3,0,0,0,0,0,8'h00,0,0});
      vt.push_back('{0,1,0,8'h04, 4,0,0,0,0,0,8'h00,0,0});
      vt.push_back('{0,1,0,8'h05, 5,0,0,0,0,0,8'h00,0,0});
      vt.push_back('{0,1,0,8'h06, 6,0,0,1,0,0,8'h00,0,0});
      vt.push_back('{0,1,0,8'h07, 7,0,0,1,0,0,8'h00,0,0});
      vt.push_back('{0,1,0,8'h08, 8,0,1,1,0,0,8'h00,0,0});
      vt.push_back('{0,1,0,8'h09, 8,0,1,1,0,0,8'h00,1,0});
      vt.push_back('{0,0,1,8'h00, 7,0,0,1,0,1,8'h01,1,0});
      vt.push_back('{0,0,1,8'h00, 6,0,0,1,0,1,8'h02,1,0});
      vt.push_back('{0,0,1,8'h00, 5,0,0,0,0,1,8'h03,1,0});
      vt.push_back('{0,0,1,8'h00, 4,0,0,0,0,1,8'h04,1,0});
      vt.push_back('{0,0,1,8'h00, 3,0,0,0,0,1,8'h05,1,0});
      vt.push_back('{0,0,1,8'h00, 2,0,0,0,1,1,8'h06,1,0});
      vt.push_back('{0,0,1,8'h00, 1,0,0,0,1,1,8'h07,1,0});
      vt.push_back('{0,0,1,8'h00, 0,1,0,0,1,1,8'h08,1,0});
      vt.push_back('{0,0,1,8'h00, 0,1,0,0,1,0,8'h08,1,1});
      vt.push_back('{1,0,0,8'h00, 0,1,0,0,1,0,8'h00,0,0});
      vt.push_back('{0,1,1,8'h55, 1,0,0,0,1,0,8'h00,0,1});
      vt.push_back('{0,0,1,8'h00, 0,1,0,0,1,1,8'h55,0,1});
      vt.push_back('{1,0,0,8'h00, 0,1,0,0,1,0,8'h00,0,0});
      rst_n = 1'b0;
      drv_s(0, 0, 8'h00, 0);
      f_clr = 1'b0;
      drv_f(0, 8'h00, 0);
`ifdef SYNC_FIFO_PARITY_EN
      s_pinj = 1'b0;
      f_pinj = 1'b0;
`endif
      repeat (2) tick();
      chk_s("reset", 0, 1, 0, 0, 1, 0, 8'h00, 0, 0);
      chk_f("fw reset", 0, 1, 0, 8'h00, 1);
      rst_n = 1'b1;
      for (int i = 0; i < vt.size(); i++) begin
         drv_s(vt[i].clr, vt[i].wr, vt[i].wd, vt[i].rd);
         tick();
         chk_s($sformatf("vec%0d", i), vt[i].cnt, vt[i].emp, vt[i].ful, vt[i].af, vt[i].ae,
               vt[i].vld, vt[i].rdd, vt[i].ov, vt[i].un);
      end
      for (int i = 0; i < 8; i++) begin
         drv_s(0, 1, 8'(8'h60 + i), 0);
         tick();
         chk($sformatf("fill%0d count", i), 32'(s_cnt), 32'(i + 1));
      end
      chk("fill full", 32'(s_full), 32'd1);
      drv_s(0, 1, 8'h99, 1);
      tick();
      chk_s("full wr+rd", 7, 0, 0, 1, 0, 1, 8'h60, 1, 0);
      for (int i = 0; i < 7; i++) begin
         drv_s(0, 0, 8'h00, 1);
         tick();
         chk($sformatf("drain%0d rd_data", i), 32'(s_rdd), 32'(8'h61 + i));
         chk($sformatf("drain%0d count", i), 32'(s_cnt), 32'(6 - i));
      end
      drv_s(0, 0, 8'h00, 0);
      tick();
      chk("valid pulse end", 32'(s_vld), 32'd0);
      chk("rd_data hold", 32'(s_rdd), 32'h67);
      for (int i = 0; i < 20; i++) begin
         drv_s(0, 1, 8'(8'h10 + i), 0);
         tick();
         chk($sformatf("wrap%0d wr count", i), 32'(s_cnt), 32'd1);
         chk($sformatf("wrap%0d wr valid", i), 32'(s_vld), 32'd0);
         drv_s(0, 0, 8'h00, 1);
         tick();
         chk($sformatf("wrap%0d valid", i), 32'(s_vld), 32'd1);
         chk($sformatf("wrap%0d rd_data", i), 32'(s_rdd), 32'(8'h10 + i));
         chk($sformatf("wrap%0d empty", i), 32'(s_emp), 32'd1);
      end
      drv_s(0, 0, 8'h00, 0);
      tick();
      chk_s("wrap end", 0, 1, 0, 0, 1, 0, 8'h23, 1, 0);
`ifdef SYNC_FIFO_PARITY_EN
      drv_s(1, 0, 8'h00, 0);
      tick();
      s_pinj = 1'b1;
      drv_s(0, 1, 8'h05, 0);
      tick();
      s_pinj = 1'b0;
      drv_s(0, 1, 8'h06, 0);
      tick();
      drv_s(0, 0, 8'h00, 1);
      tick();
      chk("par word0 data", 32'(s_rdd), 32'h05);
      chk("par word0 err", 32'(s_perr), 32'd1);
      tick();
      chk("par word1 data", 32'(s_rdd), 32'h06);
      chk("par word1 err", 32'(s_perr), 32'd0);
      drv_s(0, 0, 8'h00, 0);
      tick();
`endif
      drv_f(1, 8'hAA, 0);
      tick();
      chk_f("fw wr AA", 1, 1, 0, 8'h00, 0);
      drv_f(0, 8'h00, 0);
      tick();
      chk_f("fw AA shown", 1, 0, 1, 8'hAA, 1);
      drv_f(1, 8'hBB, 0);
      tick();
      chk_f("fw wr BB", 2, 0, 1, 8'hAA, 1);
      drv_f(1, 8'hCC, 0);
      tick();
      chk_f("fw wr CC", 3, 0, 1, 8'hAA, 1);
      drv_f(0, 8'h00, 1);
      tick();
      chk_f("fw pop1", 2, 0, 1, 8'hBB, 1);
      tick();
      chk_f("fw pop2", 1, 0, 1, 8'hCC, 1);
      tick();
      chk_f("fw pop3", 0, 1, 0, 8'h00, 0);
      chk("fw underflow", 32'(f_un), 32'd0);
      for (int i = 0; i < 8; i++) begin
         drv_f(1, 8'(8'h30 + i), 0);
         tick();
         chk($sformatf("fw fill%0d count", i), 32'(f_cnt), 32'(i + 1));
      end
      chk("fw full", 32'(f_full), 32'd1);
      drv_f(1, 8'h38, 0);
      tick();
      chk("fw overflow", 32'(f_ov), 32'd1);
      chk("fw count at full", 32'(f_cnt), 32'd8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("fw drain%0d valid", i), 32'(f_vld), 32'd1);
         chk($sformatf("fw drain%0d rd_data", i), 32'(f_rdd), 32'(8'h30 + i));
         drv_f(0, 8'h00, 1);
         tick();
      end
      drv_f(0, 8'h00, 0);
      chk_f("fw drained", 0, 1, 0, 8'h00, 0);
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
